anc_frame_scheduler: RTL and testbench
======================================

Name: anc_frame_scheduler

Overview:
- Per-sample sequencer for the 32-tap adaptive filter datapath and its normalisation divider.
- On each new sample it runs one frame: filter MAC window, error capture, divider run, then weight write-back sweep.
- Holds at most one early sample as pending; counts samples dropped by overrun.
- Sits between the ADC sample strobe and the filter, divider and weight-RAM blocks.

Parameters:
- NUM_TAPS, 32, taps per frame; length of the weight write-back sweep.
- FILT_CYC, 35, cycles the filter run signal stays high. Covers the 34-cycle MAC count plus one pipeline cycle.
- DIV_TIMEOUT, 64, maximum cycles spent waiting for div_done.
- CNT_W, 16, width of the frame and overrun counters.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- enable  in  1  allows new frames to start; sampled only in IDLE
- sample_valid  in  1  one-cycle strobe: a new reference/primary sample is in the buffers
- div_done  in  1  divider result valid (one-cycle pulse)
- filt_run  out  1  drives the filter's adap_filter_state
- e_capture  out  1  one-cycle pulse while filt_run is low, in which the filter latches e
- div_start  out  1  one-cycle pulse that starts the divider
- div_state  out  1  high while waiting on the divider
- wt_we  out  1  weight write enable
- wt_idx  out  5  weight index being written (log2 NUM_TAPS bits)
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse when a frame completes
- div_err  out  1  sticky divider-timeout flag; cleared only by reset
- frame_cnt  out  CNT_W  completed frames; wraps
- overrun_cnt  out  CNT_W  dropped samples; saturates at all-ones

Behaviour:
- Reset: all outputs 0 and state IDLE. pending=0, counters=0. Reset mid-frame aborts the frame immediately with no completion pulse.
- IDLE → FILT: taken when enable=1 and (sample_valid=1 or pending=1). Consuming the start clears pending.
- FILT:
  - filt_run=1 from the first cycle after the start strobe, for exactly FILT_CYC cycles.
  - Internal cycle counter runs 0..FILT_CYC-1, then → ERR.
- ERR: one cycle with filt_run=0 and e_capture=1, then → DIV.
- DIV:
  - div_start=1 in the first DIV cycle only; div_state=1 throughout DIV.
  - div_done → UPD on the next cycle.
  - If DIV_TIMEOUT cycles elapse without div_done: set div_err, skip UPD, go to DONE.
  - A div_done outside DIV is ignored.
- UPD:
  - wt_we=1 for exactly NUM_TAPS cycles, with wt_idx = 0,1,…,NUM_TAPS-1 (one index per cycle).
  - Then → DONE.
  - wt_idx is 0 whenever wt_we=0.
- DONE:
  - One cycle: frame_done=1 and frame_cnt+1 (wraps). Also reached after a timeout.
  - Next state is FILT if enable=1 and (pending or sample_valid this cycle); otherwise IDLE.
- Sample while busy:
  - If pending=0, set pending=1.
  - If pending=1, the sample is dropped and overrun_cnt increments (saturates).
  - Sample arriving in the same cycle the FSM starts from pending: it becomes the new pending.
- enable=0 mid-frame: the current frame still completes. pending is retained until enable returns.
- Frame length with div_done after k DIV cycles: FILT_CYC + 1 + k + NUM_TAPS + 1 cycles.

Decomposition:
- Shared package holds:
  - state encoding: IDLE, FILT, ERR, DIV, UPD, DONE;
  - the defaults NUM_TAPS=32, FILT_CYC=35, DIV_TIMEOUT=64.
- One sub-module: anc_sat_counter (saturating/wrapping CNT_W counter with a mode parameter), used for both frame_cnt and overrun_cnt.
- The state-cycle counter stays inline.

Test Plan:
- Reset then sample_valid at cycle 10, div_done 5 cycles into DIV:
  - filt_run high cycles 11–45; e_capture at 46; div_start at 47;
  - wt_we with wt_idx 0..31 over cycles 53–84; frame_done at 85; frame_cnt=1.
- div_done never asserted → div_err=1 after 64 DIV cycles, no wt_we, frame_done pulses, frame_cnt=1.
- Three sample_valid strobes during one frame → pending=1 and overrun_cnt=2; a second frame starts directly from DONE.
- overrun_cnt preloaded at 16'hFFFE with three drops → holds at 16'hFFFF.
- enable=0 with sample_valid in IDLE → stays IDLE and busy=0. Raising enable runs the pending frame.
- rstn pulsed low mid-UPD (wt_idx=12) → wt_we=0, busy=0, counters=0 asynchronously; no frame_done.

Source files
------------

// File: rtl/anc_frame_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : anc_frame_scheduler_pkg
//  Purpose  : Shared defaults and FSM state encoding for the ANC frame
//             scheduler and its helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package anc_frame_scheduler_pkg;

   localparam int DEF_NUM_TAPS    = 32;
   localparam int DEF_FILT_CYC    = 35;
   localparam int DEF_DIV_TIMEOUT = 64;
   localparam int DEF_CNT_W       = 16;

   // Frame sequencer states
   localparam logic [2:0] c_st_idle = 3'd0;
   localparam logic [2:0] c_st_filt = 3'd1;
   localparam logic [2:0] c_st_err  = 3'd2;
   localparam logic [2:0] c_st_div  = 3'd3;
   localparam logic [2:0] c_st_upd  = 3'd4;
   localparam logic [2:0] c_st_done = 3'd5;

   // Largest of three lengths; sizes the shared per-state cycle counter
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/anc_frame_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : anc_frame_scheduler_if
//  Purpose  : Sample strobe, divider handshake, filter/weight controls and
//             status of the ANC frame scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
interface anc_frame_scheduler_if
   import anc_frame_scheduler_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int IDX_W = $clog2(DEF_NUM_TAPS)
);
   logic             enable;
   logic             sample_valid;
   logic             div_done;
   logic             filt_run;
   logic             e_capture;
   logic             div_start;
   logic             div_state;
   logic             wt_we;
   logic [IDX_W-1:0] wt_idx;
   logic             busy;
   logic             frame_done;
   logic             div_err;
   logic [CNT_W-1:0] frame_cnt;
   logic [CNT_W-1:0] overrun_cnt;

   // Scheduler side
   modport master (
      input  enable, sample_valid, div_done,
      output filt_run, e_capture, div_start, div_state, wt_we, wt_idx,
             busy, frame_done, div_err, frame_cnt, overrun_cnt
   );

   // Surrounding system side
   modport slave (
      output enable, sample_valid, div_done,
      input  filt_run, e_capture, div_start, div_state, wt_we, wt_idx,
             busy, frame_done, div_err, frame_cnt, overrun_cnt
   );
endinterface
`default_nettype wire

// File: rtl/anc_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : anc_sat_counter
//  Purpose  : Event counter that either wraps or sticks at all-ones.
//  Revision : 1.0 - initial release
// ============================================================================
module anc_sat_counter
   import anc_frame_scheduler_pkg::*;
#(
   parameter int CNT_W    = DEF_CNT_W,
   parameter bit SATURATE = 1'b0
)(
   input  logic             clk,
   input  logic             rstn,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);
   localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_next;

   generate
      if (SATURATE) begin : g_sat
         // Hold at all-ones once reached
         always_comb w_next = (&r_count) ? r_count : (r_count + c_one);
      end else begin : g_wrap
         // Plain modulo count
         always_comb w_next = r_count + c_one;
      end
   endgenerate

   // Count register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         r_count <= '0;
      else if (inc)
         r_count <= w_next;
   end

   assign count = r_count;
endmodule
`default_nettype wire

// File: rtl/anc_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : anc_frame_scheduler
//  Purpose  : Per-sample frame sequencer: filter MAC window, error capture,
//             normalisation divide, weight write-back sweep. Buffers one
//             early sample and counts overrun drops.
//  Revision : 1.0 - initial release
// ============================================================================
module anc_frame_scheduler
   import anc_frame_scheduler_pkg::*;
#(
   parameter int NUM_TAPS    = DEF_NUM_TAPS,
   parameter int FILT_CYC    = DEF_FILT_CYC,
   parameter int DIV_TIMEOUT = DEF_DIV_TIMEOUT,
   parameter int CNT_W       = DEF_CNT_W
)(
   input  logic                  clk,
   input  logic                  rstn,
   anc_frame_scheduler_if.master bus
);
   localparam int c_idx_w = $clog2(NUM_TAPS);
   localparam int c_cyc_w = $clog2(max3(NUM_TAPS, FILT_CYC, DIV_TIMEOUT) + 1);

   localparam logic [c_cyc_w-1:0] c_filt_last = c_cyc_w'(FILT_CYC - 1);
   localparam logic [c_cyc_w-1:0] c_div_last  = c_cyc_w'(DIV_TIMEOUT - 1);
   localparam logic [c_cyc_w-1:0] c_upd_last  = c_cyc_w'(NUM_TAPS - 1);
   localparam logic [c_cyc_w-1:0] c_cyc_one   = c_cyc_w'(1);

   logic [2:0]         r_state;
   logic [2:0]         w_next;
   logic [c_cyc_w-1:0] r_cyc;
   logic               r_pending;
   logic               r_div_err;
   logic               w_launch_ok;
   logic               w_start;
   logic               w_timeout;
   logic               w_drop;
   logic               w_frame_inc;
   logic [CNT_W-1:0]   w_frame_cnt;
   logic [CNT_W-1:0]   w_overrun_cnt;

   // A frame may start when enabled and either a fresh or a buffered sample exists
   assign w_launch_ok = bus.enable && (bus.sample_valid || r_pending);
   assign w_start     = ((r_state == c_st_idle) || (r_state == c_st_done)) && w_launch_ok;
   assign w_timeout   = (r_state == c_st_div) && !bus.div_done && (r_cyc == c_div_last);
   // A sample not consumed by a start overflows only if one is already buffered
   assign w_drop      = bus.sample_valid && !w_start && r_pending;
   assign w_frame_inc = (r_state == c_st_done);

   // Next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         c_st_idle: if (w_launch_ok) w_next = c_st_filt;
         c_st_filt: if (r_cyc == c_filt_last) w_next = c_st_err;
         c_st_err:  w_next = c_st_div;
         c_st_div: begin
            if (bus.div_done)              w_next = c_st_upd;
            else if (r_cyc == c_div_last)  w_next = c_st_done;
         end
         c_st_upd:  if (r_cyc == c_upd_last) w_next = c_st_done;
         c_st_done: w_next = w_launch_ok ? c_st_filt : c_st_idle;
         default:   w_next = c_st_idle;
      endcase
   end

   // State register and per-state cycle counter (restarts on every state entry)
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= c_st_idle;
         r_cyc   <= '0;
      end else begin
         r_state <= w_next;
         if ((w_next != r_state) || (r_state == c_st_idle))
            r_cyc <= '0;
         else
            r_cyc <= r_cyc + c_cyc_one;
      end
   end

   // Pending sample buffer; a sample coinciding with a start from pending replaces it
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         r_pending <= 1'b0;
      else if (w_start)
         r_pending <= r_pending && bus.sample_valid;
      else if (bus.sample_valid)
         r_pending <= 1'b1;
   end

   // Sticky divider timeout flag
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         r_div_err <= 1'b0;
      else if (w_timeout)
         r_div_err <= 1'b1;
   end

   anc_sat_counter #(.CNT_W(CNT_W), .SATURATE(1'b0)) u_frame_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .inc   (w_frame_inc),
      .count (w_frame_cnt)
   );

   anc_sat_counter #(.CNT_W(CNT_W), .SATURATE(1'b1)) u_overrun_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .inc   (w_drop),
      .count (w_overrun_cnt)
   );

   assign bus.filt_run    = (r_state == c_st_filt);
   assign bus.e_capture   = (r_state == c_st_err);
   assign bus.div_state   = (r_state == c_st_div);
   assign bus.div_start   = (r_state == c_st_div) && (r_cyc == '0);
   assign bus.wt_we       = (r_state == c_st_upd);
   assign bus.wt_idx      = (r_state == c_st_upd) ? r_cyc[c_idx_w-1:0] : '0;
   assign bus.busy        = (r_state != c_st_idle);
   assign bus.frame_done  = (r_state == c_st_done);
   assign bus.div_err     = r_div_err;
   assign bus.frame_cnt   = w_frame_cnt;
   assign bus.overrun_cnt = w_overrun_cnt;
endmodule
`default_nettype wire

// File: tb/tb_anc_frame_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_anc_frame_scheduler
//  Purpose  : Directed self-checking bench for anc_frame_scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_anc_frame_scheduler;

   logic clk = 1'b0;
   logic rstn;
   int   checks   = 0;
   int   failures = 0;

   anc_frame_scheduler_if #(.CNT_W(16), .IDX_W(5)) bus ();

   anc_frame_scheduler dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // {filt_run, e_capture, div_start, div_state, wt_we, wt_idx[4:0], frame_done, div_err, busy}
   function automatic logic [12:0] got_trace();
      return {bus.filt_run, bus.e_capture, bus.div_start, bus.div_state, bus.wt_we,
              bus.wt_idx, bus.frame_done, bus.div_err, bus.busy};
   endfunction

   // Expected controls in frame cycle c (1 = first FILT cycle); div_done seen in DIV cycle k
   function automatic logic [12:0] exp_trace(input int c, input int k, input bit to);
      int         last_div;
      int         done_c;
      logic       fr, ec, ds, dv, we, fd, de;
      logic [4:0] idx;
      last_div = to ? (36 + 64) : (36 + k);
      done_c   = to ? (last_div + 1) : (last_div + 32 + 1);
      fr  = (c >= 1) && (c <= 35);
      ec  = (c == 36);
      ds  = (c == 37);
      dv  = (c >= 37) && (c <= last_div);
      we  = !to && (c > last_div) && (c < done_c);
      idx = we ? 5'(c - last_div - 1) : 5'd0;
      fd  = (c == done_c);
      de  = to && (c >= done_c);
      return {fr, ec, ds, dv, we, idx, fd, de, 1'b1};
   endfunction

   task automatic do_reset();
      rstn             = 1'b0;
      bus.enable       = 1'b1;
      bus.sample_valid = 1'b0;
      bus.div_done     = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      step();
   endtask

   task automatic test_reset();
      rstn             = 1'b0;
      bus.enable       = 1'b0;
      bus.sample_valid = 1'b0;
      bus.div_done     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({got_trace(), bus.frame_cnt, bus.overrun_cnt} !== 45'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=0", {got_trace(), bus.frame_cnt, bus.overrun_cnt});
      end
      rstn = 1'b1;
      step();
      checks++;
      if (got_trace() !== 13'd0) begin
         failures++;
         $display("FAIL reset_idle got=%b exp=0", got_trace());
      end
   endtask

   task automatic test_basic_frame();
      logic [12:0] e;
      logic [12:0] g;
      do_reset();
      bus.sample_valid = 1'b1;
      step();
      bus.sample_valid = 1'b0;
      for (int c = 1; c <= 75; c++) begin
         e = exp_trace(c, 6, 1'b0);
         g = got_trace();
         checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL basic_trace c=%0d got=%b exp=%b", c, g, e);
         end
         bus.div_done = (c == 42);
         step();
      end
      bus.div_done = 1'b0;
      checks++;
      if ({bus.frame_cnt, bus.busy} !== {16'd1, 1'b0}) begin
         failures++;
         $display("FAIL basic_end frame_cnt=%0d busy=%b exp 1/0", bus.frame_cnt, bus.busy);
      end
   endtask

   task automatic test_timeout();
      logic [12:0] e;
      logic [12:0] g;
      do_reset();
      bus.sample_valid = 1'b1;
      step();
      bus.sample_valid = 1'b0;
      for (int c = 1; c <= 101; c++) begin
         e = exp_trace(c, 0, 1'b1);
         g = got_trace();
         checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL timeout_trace c=%0d got=%b exp=%b", c, g, e);
         end
         bus.div_done = (c == 10);   // outside DIV: must be ignored
         step();
      end
      bus.div_done = 1'b0;
      checks++;
      if ({bus.frame_cnt, bus.div_err, bus.busy} !== {16'd1, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL timeout_end frame_cnt=%0d div_err=%b busy=%b exp 1/1/0",
                  bus.frame_cnt, bus.div_err, bus.busy);
      end
      step();
      checks++;
      if (bus.div_err !== 1'b1) begin
         failures++;
         $display("FAIL div_err_sticky got=%b exp=1", bus.div_err);
      end
   endtask

   task automatic test_overrun();
      do_reset();
      bus.sample_valid = 1'b1;
      step();
      for (int c = 1; c <= 151; c++) begin
         if (c == 75) begin
            checks++;
            if ({bus.frame_done, bus.overrun_cnt} !== {1'b1, 16'd2}) begin
               failures++;
               $display("FAIL overrun_done1 frame_done=%b overrun=%0d exp 1/2", bus.frame_done, bus.overrun_cnt);
            end
         end
         if (c == 76) begin
            checks++;
            if ({bus.filt_run, bus.frame_done} !== 2'b10) begin
               failures++;
               $display("FAIL overrun_restart filt_run=%b frame_done=%b exp 1/0", bus.filt_run, bus.frame_done);
            end
         end
         if (c == 150) begin
            checks++;
            if ({bus.frame_done, bus.overrun_cnt} !== {1'b1, 16'd2}) begin
               failures++;
               $display("FAIL overrun_done2 frame_done=%b overrun=%0d exp 1/2", bus.frame_done, bus.overrun_cnt);
            end
         end
         if (c == 151) begin
            checks++;
            if ({bus.filt_run, bus.frame_cnt} !== {1'b1, 16'd2}) begin
               failures++;
               $display("FAIL overrun_repend filt_run=%b frame_cnt=%0d exp 1/2", bus.filt_run, bus.frame_cnt);
            end
         end
         bus.sample_valid = (c == 5) || (c == 20) || (c == 50) || (c == 75);
         bus.div_done     = (c == 42) || (c == 117);
         step();
      end
      bus.sample_valid = 1'b0;
      bus.div_done     = 1'b0;
   endtask

   task automatic test_enable();
      do_reset();
      bus.enable       = 1'b0;
      bus.sample_valid = 1'b1;
      step();
      bus.sample_valid = 1'b0;
      for (int c = 1; c <= 86; c++) begin
         if (c == 1 || c == 5 || c == 81 || c == 85) begin
            checks++;
            if (bus.busy !== 1'b0) begin
               failures++;
               $display("FAIL enable_idle c=%0d busy=%b exp=0", c, bus.busy);
            end
         end
         if (c == 6 || c == 86) begin
            checks++;
            if ({bus.filt_run, bus.busy} !== 2'b11) begin
               failures++;
               $display("FAIL enable_start c=%0d filt_run=%b busy=%b exp 1/1", c, bus.filt_run, bus.busy);
            end
         end
         if (c == 80) begin
            checks++;
            if (bus.frame_done !== 1'b1) begin
               failures++;
               $display("FAIL enable_done frame_done=%b exp=1", bus.frame_done);
            end
         end
         bus.enable       = ((c >= 5) && (c < 15)) || (c >= 85);
         bus.sample_valid = (c == 25);
         bus.div_done     = (c == 47);
         step();
      end
      bus.sample_valid = 1'b0;
      bus.div_done     = 1'b0;
   endtask

   task automatic test_reset_mid_upd();
      bit bad;
      do_reset();
      bus.sample_valid = 1'b1;
      step();
      for (int c = 1; c < 130; c++) begin
         bus.sample_valid = (c == 5) || (c == 6);
         bus.div_done     = (c == 42) || (c == 117);
         step();
      end
      bus.div_done = 1'b0;
      checks++;
      if ({bus.wt_we, bus.wt_idx, bus.frame_cnt, bus.overrun_cnt} !== {1'b1, 5'd12, 16'd1, 16'd1}) begin
         failures++;
         $display("FAIL pre_reset we=%b idx=%0d frame_cnt=%0d overrun=%0d exp 1/12/1/1",
                  bus.wt_we, bus.wt_idx, bus.frame_cnt, bus.overrun_cnt);
      end
      #2;
      rstn = 1'b0;
      #1;
      checks++;
      if ({bus.wt_we, bus.wt_idx, bus.busy, bus.frame_cnt, bus.overrun_cnt} !== 39'd0) begin
         failures++;
         $display("FAIL async_reset we=%b idx=%0d busy=%b frame_cnt=%0d overrun=%0d exp all 0",
                  bus.wt_we, bus.wt_idx, bus.busy, bus.frame_cnt, bus.overrun_cnt);
      end
      step();
      rstn = 1'b1;
      bad  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (bus.frame_done !== 1'b0 || bus.busy !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL post_reset_quiet frame_done or busy asserted after mid-frame reset");
      end
   endtask

   task automatic test_saturation();
      do_reset();
      bus.enable       = 1'b0;
      bus.sample_valid = 1'b1;
      repeat (65535) step();
      checks++;
      if ({bus.overrun_cnt, bus.busy} !== {16'hFFFE, 1'b0}) begin
         failures++;
         $display("FAIL sat_preload overrun=%h busy=%b exp fffe/0", bus.overrun_cnt, bus.busy);
      end
      repeat (3) step();
      bus.sample_valid = 1'b0;
      checks++;
      if (bus.overrun_cnt !== 16'hFFFF) begin
         failures++;
         $display("FAIL sat_hold overrun=%h exp=ffff", bus.overrun_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_timeout();
      test_overrun();
      test_enable();
      test_reset_mid_upd();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
